// File: rtl/wieg_regeling.sv
// Rocking controller: a hill-climbing level search driven by stress-trend flags,
// plus a clk4-paced half-period generator that swings the rocking direction.
module wieg_regeling #(
  parameter int unsigned STAP_GELIJK = 2,
  parameter int unsigned BASIS_HALF  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk4,
  input  logic       clk12,
  input  logic       aan,
  input  logic       gedaald,
  input  logic       gelijk,
  output logic [2:0] niveau,
  output logic       richting,
  output logic       motor,
  output logic [1:0] status
);

  typedef enum logic [1:0] {
    uit    = 2'b00,
    omhoog = 2'b01,
    omlaag = 2'b10,
    houd   = 2'b11
  } state_t;

  state_t     state_r;
  logic [2:0] gcnt_r;
  logic [4:0] hcnt_r;
  logic [4:0] half_s;
  logic [4:0] half_last_s;
  logic [2:0] gcnt_inc_s;
  logic       step_s;

  assign status = state_r;

  // Half-period from the current (pre-update) level and gelijk-threshold detection
  always_comb begin
    half_s      = 5'(BASIS_HALF) - {1'b0, niveau, 1'b0};
    half_last_s = half_s - 5'd1;
    gcnt_inc_s  = gcnt_r + 3'd1;
    step_s      = (gcnt_inc_s == 3'(STAP_GELIJK));
  end

  // Level search FSM, gelijk counter and direction generator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= uit;
      niveau   <= 3'd0;
      gcnt_r   <= 3'd0;
      hcnt_r   <= 5'd0;
      richting <= 1'b0;
      motor    <= 1'b0;
    end else if (!aan) begin
      state_r  <= uit;
      niveau   <= 3'd0;
      gcnt_r   <= 3'd0;
      hcnt_r   <= 5'd0;
      richting <= 1'b0;
      motor    <= 1'b0;
    end else if (state_r == uit) begin
      state_r  <= omhoog;
      niveau   <= 3'd1;
      gcnt_r   <= 3'd0;
      hcnt_r   <= 5'd0;
      richting <= 1'b0;
      motor    <= 1'b1;
    end else begin
      motor <= 1'b1;
      if (clk4) begin
        // a counter already past a freshly shortened period wraps here
        if (hcnt_r >= half_last_s) begin
          hcnt_r   <= 5'd0;
          richting <= ~richting;
        end else begin
          hcnt_r <= hcnt_r + 5'd1;
        end
      end
      if (clk12) begin
        if (gedaald) begin
          state_r <= houd;
          gcnt_r  <= 3'd0;
        end else if (gelijk) begin
          if (step_s) begin
            gcnt_r <= 3'd0;
            case (state_r)
              omhoog: begin
                if (niveau == 3'd7) state_r <= omlaag;
                else                niveau  <= niveau + 3'd1;
              end
              omlaag: begin
                if (niveau == 3'd1) state_r <= omhoog;
                else                niveau  <= niveau - 3'd1;
              end
              default: state_r <= state_r;
            endcase
          end else begin
            gcnt_r <= gcnt_inc_s;
          end
        end else begin
          // stress rose: reverse the search direction
          gcnt_r <= 3'd0;
          case (state_r)
            omhoog: begin
              state_r <= omlaag;
              niveau  <= (niveau > 3'd1) ? niveau - 3'd1 : 3'd1;
            end
            default: begin
              state_r <= omhoog;
              niveau  <= (niveau < 3'd7) ? niveau + 3'd1 : 3'd7;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wieg_regeling.sv
// Self-checking bench for wieg_regeling: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_wieg_regeling;

  localparam int STAP  = 2;
  localparam int BASIS = 16;

  logic       clk, reset, clk4, clk12, aan, gedaald, gelijk;
  logic [2:0] niveau;
  logic       richting, motor;
  logic [1:0] status;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state (status codes: 0 off, 1 up, 2 down, 3 hold)
  int m_state, m_niv, m_gc, m_hc, m_rich;

  wieg_regeling #(.STAP_GELIJK(STAP), .BASIS_HALF(BASIS)) dut (
    .clk(clk), .reset(reset), .clk4(clk4), .clk12(clk12), .aan(aan),
    .gedaald(gedaald), .gelijk(gelijk), .niveau(niveau), .richting(richting),
    .motor(motor), .status(status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_niv = 0; m_gc = 0; m_hc = 0; m_rich = 0;
  endtask

  task automatic model_step(input bit a, input bit c4, input bit c12, input bit gd, input bit gl);
    int h;
    if (!a) begin
      model_reset();
    end else if (m_state == 0) begin
      m_state = 1; m_niv = 1; m_gc = 0; m_hc = 0; m_rich = 0;
    end else begin
      h = BASIS - 2 * m_niv;
      if (c4) begin
        if (m_hc >= h - 1) begin m_hc = 0; m_rich = 1 - m_rich; end
        else m_hc = m_hc + 1;
      end
      if (c12) begin
        if (gd) begin
          m_state = 3; m_gc = 0;
        end else if (gl) begin
          m_gc = m_gc + 1;
          if (m_gc == STAP) begin
            m_gc = 0;
            if (m_state == 1) begin
              if (m_niv + 1 > 7) m_state = 2; else m_niv = m_niv + 1;
            end else if (m_state == 2) begin
              if (m_niv - 1 < 1) m_state = 1; else m_niv = m_niv - 1;
            end
          end
        end else begin
          m_gc = 0;
          if (m_state == 1) begin
            m_state = 2; m_niv = (m_niv - 1 < 1) ? 1 : m_niv - 1;
          end else begin
            m_state = 1; m_niv = (m_niv + 1 > 7) ? 7 : m_niv + 1;
          end
        end
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".status"},   int'(status),   m_state);
    chk({tag, ".niveau"},   int'(niveau),   m_niv);
    chk({tag, ".richting"}, int'(richting), m_rich);
    chk({tag, ".motor"},    int'(motor),    (m_state != 0) ? 1 : 0);
  endtask

  task automatic step(input string tag, input bit a, input bit c4, input bit c12,
                      input bit gd, input bit gl);
    aan = a; clk4 = c4; clk12 = c12; gedaald = gd; gelijk = gl;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step(a, c4, c12, gd, gl);
    #1;
    cmp_all(tag);
  endtask

  initial begin
    reset = 1'b0; aan = 1'b1; clk4 = 1'b0; clk12 = 1'b0; gedaald = 1'b0; gelijk = 1'b0;
    model_reset();

    // reset held with aan=1
    step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_reset_motor", int'(motor), 0);
    reset = 1'b1;
    step("enable", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_enable_status", int'(status), 1);
    chk("tp_enable_niveau", int'(niveau), 1);

    // up-search
    for (int i = 0; i < 4; i++) step("upsearch", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tp_upsearch_niveau", int'(niveau), 3);

    // settle, then reversal from hold
    step("settle", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("tp_settle_status", int'(status), 3);
    step("unsettle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tp_unsettle_niveau", int'(niveau), 4);

    // saturation at the top
    for (int i = 0; i < 8; i++) step("saturate", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tp_sat_niveau", int'(niveau), 7);
    chk("tp_sat_status", int'(status), 2);
    step("sat_rev", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tp_satrev_niveau", int'(niveau), 7);
    chk("tp_satrev_status", int'(status), 1);

    // walk down to level 3 and hold there
    step("down", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("down", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("hold3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tp_hold3_niveau", int'(niveau), 3);

    // pacing at H=10
    for (int i = 0; i < 9; i++) step("pace", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_pace9_richting", int'(richting), 0);
    step("pace", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_pace10_richting", int'(richting), 1);
    for (int i = 0; i < 15; i++) step("pace", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_pace25_richting", int'(richting), 0);

    // raise to level 7 with the counter parked at 5, then one clk4 tick
    step("raise", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("raise", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tp_raise_niveau", int'(niveau), 7);
    step("fast", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_fast_richting", int'(richting), 1);

    // disable on a step-threshold evaluation
    step("prestep", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("disable", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("tp_disable_status", int'(status), 0);
    chk("tp_disable_niveau", int'(niveau), 0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0));
    end

    // async reset mid-swing
    step("pre_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step("pre_async", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    cmp_all("async_rst");
    #1 reset = 1'b1;
    step("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_restart_status", int'(status), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
